// File: rtl/spi_mux_pkg.sv
// Shared types and command-byte layout for the multi-channel SPI output mux.
package spi_mux_pkg;

  typedef enum logic [2:0] {
    STATE_RESET,
    STATE_IDLE,
    STATE_SHIFT,
    STATE_COMMIT,
    STATE_ERR,
    STATE_ERR_PULSE
  } state_t;

  localparam int CMD_W      = 8;
  localparam int CMD_EN_BIT = 7;
  localparam int CMD_CH_MSB = 6;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with single-cycle
// rise/fall pulses derived from the synchronised level.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_chain;
  logic                   r_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_chain <= '0;
      r_prev  <= 1'b0;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
      r_prev  <= r_chain[SYNC_STAGES-1];
    end
  end

  assign o_sync = r_chain[SYNC_STAGES-1];
  assign o_rise = r_chain[SYNC_STAGES-1] & ~r_prev;
  assign o_fall = ~r_chain[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/spi_mux_multi.sv
// SPI mode-0 slave committing command+data frames to NUM_CH output buses and
// driver enables. Define SPI_READBACK_EN to shift the addressed bus out on MISO.
//
// state           | meaning
// STATE_RESET     | wait for nCS high so a frame in flight at reset is dropped
// STATE_IDLE      | bus idle, waiting for nCS falling edge
// STATE_SHIFT     | sampling MOSI on SCK rising edges
// STATE_COMMIT    | one cycle: apply the received frame
// STATE_ERR       | overlong frame, ignore SCK until nCS rises
// STATE_ERR_PULSE | one cycle: flag frame_err, discard the frame
module spi_mux_multi
  import spi_mux_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     spi_nCS,
  input  logic                     spi_sck,
  input  logic                     spi_mosi,
  output logic                     spi_miso,
  output logic                     spi_miso_oe,
  output logic [NUM_CH*DATA_W-1:0] out,
  output logic [NUM_CH-1:0]        out_en,
  output logic                     buffer_oe,
  output logic [2:0]               status,
  output logic                     frame_err
);

  localparam int FL    = CMD_W + DATA_W;
  localparam int CNT_W = $clog2(FL + 2);

  logic w_ncs, w_ncs_rise, w_ncs_fall;
  logic w_sck, w_sck_rise, w_sck_fall;
  logic w_mosi, w_mosi_rise, w_mosi_fall;
  logic w_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ncs (
    .clk(clk), .reset(reset), .i_async(spi_nCS),
    .o_sync(w_ncs), .o_rise(w_ncs_rise), .o_fall(w_ncs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
    .clk(clk), .reset(reset), .i_async(spi_sck),
    .o_sync(w_sck), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .reset(reset), .i_async(spi_mosi),
    .o_sync(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
  );

  state_t                  r_state, w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [FL-1:0]           r_shift;
  logic [NUM_CH*DATA_W-1:0] r_out;
  logic [NUM_CH-1:0]       r_out_en;
  logic                    r_buffer_oe;
  logic                    r_sticky;

  logic [CMD_W-1:0]        w_cmd;
  logic [DATA_W-1:0]       w_data;
  logic [CMD_CH_MSB:0]     w_ch;
  logic                    w_ch_bad;
  logic                    w_shift_en;

  assign w_cmd      = r_shift[FL-1 -: CMD_W];
  assign w_data     = r_shift[DATA_W-1:0];
  assign w_ch       = w_cmd[CMD_CH_MSB:0];
  assign w_ch_bad   = (int'(w_ch) >= NUM_CH);
  // nCS rising beats a coincident SCK edge
  assign w_shift_en = (r_state == STATE_SHIFT) && w_sck_rise && !w_ncs_rise;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      STATE_RESET:     if (w_ncs) w_state_nxt = STATE_IDLE;
      STATE_IDLE:      if (w_ncs_fall) w_state_nxt = STATE_SHIFT;
      STATE_SHIFT: begin
        if (w_ncs_rise)
          w_state_nxt = (r_cnt == CNT_W'(FL)) ? STATE_COMMIT : STATE_ERR_PULSE;
        else if (w_sck_rise && r_cnt == CNT_W'(FL))
          w_state_nxt = STATE_ERR;
      end
      STATE_COMMIT: begin
        if (w_ch_bad)   w_state_nxt = STATE_ERR_PULSE;
        else if (w_ncs) w_state_nxt = STATE_IDLE;
        else            w_state_nxt = STATE_SHIFT;
      end
      STATE_ERR:       if (w_ncs_rise) w_state_nxt = STATE_ERR_PULSE;
      STATE_ERR_PULSE: w_state_nxt = w_ncs ? STATE_IDLE : STATE_SHIFT;
      default:         w_state_nxt = STATE_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= STATE_RESET;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_out       <= '0;
      r_out_en    <= '0;
      r_buffer_oe <= 1'b0;
      r_sticky    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_buffer_oe <= 1'b1;
      if (r_state != STATE_SHIFT && w_state_nxt == STATE_SHIFT) begin
        r_cnt <= '0;
      end else if (w_shift_en) begin
        r_cnt   <= r_cnt + CNT_W'(1);
        r_shift <= {r_shift[FL-2:0], w_mosi};
      end
      if (r_state == STATE_COMMIT && !w_ch_bad) begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (k == int'(w_ch)) begin
            if (w_cmd[CMD_EN_BIT]) r_out_en[k] <= w_data[0];
            else                   r_out[k*DATA_W +: DATA_W] <= w_data;
          end
        end
      end
      if (r_state == STATE_ERR_PULSE) r_sticky <= 1'b1;
    end
  end

`ifdef SPI_READBACK_EN
  logic [DATA_W-1:0] r_rb_sr;
  logic [DATA_W-1:0] w_rb_val;
  logic [CMD_W-1:0]  w_rb_cmd;
  logic              r_miso;

  // at count CMD_W the command byte sits in the low bits of the shifter
  assign w_rb_cmd = r_shift[CMD_W-1:0];

  always_comb begin
    w_rb_val = '0;
    if (!w_rb_cmd[CMD_EN_BIT]) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (k == int'(w_rb_cmd[CMD_CH_MSB:0])) w_rb_val = r_out[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_miso  <= 1'b0;
      r_rb_sr <= '0;
    end else if (r_state == STATE_SHIFT && w_sck_fall && !w_ncs_rise) begin
      if (r_cnt == CNT_W'(CMD_W)) begin
        r_miso  <= w_rb_val[DATA_W-1];
        r_rb_sr <= w_rb_val << 1;
      end else if (r_cnt > CNT_W'(CMD_W) && r_cnt < CNT_W'(FL)) begin
        r_miso  <= r_rb_sr[DATA_W-1];
        r_rb_sr <= r_rb_sr << 1;
      end
    end
  end

  assign spi_miso    = r_miso;
  assign spi_miso_oe = (r_state == STATE_SHIFT) && (r_cnt >= CNT_W'(CMD_W)) &&
                       (r_cnt < CNT_W'(FL));
  assign w_unused    = ^{w_sck, w_mosi_rise, w_mosi_fall};
`else
  assign spi_miso    = 1'b0;
  assign spi_miso_oe = 1'b0;
  assign w_unused    = ^{w_sck, w_sck_fall, w_mosi_rise, w_mosi_fall};
`endif

  assign out       = r_out;
  assign out_en    = r_out_en;
  assign buffer_oe = r_buffer_oe;
  assign frame_err = (r_state == STATE_ERR_PULSE);
  assign status    = {r_sticky,
                      !w_ncs && (r_state == STATE_SHIFT || r_state == STATE_ERR),
                      reset};

endmodule

// File: tb/tb_spi_mux_multi.sv
// Directed bench for spi_mux_multi (NUM_CH=4, DATA_W=8); readback checks are
// enabled when SPI_READBACK_EN is defined.
module tb_spi_mux_multi;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;
  localparam int HALF   = 5;

  logic                     clk;
  logic                     reset;
  logic                     spi_nCS;
  logic                     spi_sck;
  logic                     spi_mosi;
  logic                     spi_miso;
  logic                     spi_miso_oe;
  logic [NUM_CH*DATA_W-1:0] out;
  logic [NUM_CH-1:0]        out_en;
  logic                     buffer_oe;
  logic [2:0]               status;
  logic                     frame_err;

  int          n_cmp;
  int          n_err;
  int          n_ferr;
  logic [63:0] rb_bits;
  logic        oe_seen;

  spi_mux_multi #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .spi_nCS(spi_nCS), .spi_sck(spi_sck),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .out(out), .out_en(out_en), .buffer_oe(buffer_oe), .status(status),
    .frame_err(frame_err)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  always @(negedge clk) if (frame_err === 1'b1) n_ferr++;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bits(input int n, input logic [63:0] v);
    for (int i = n - 1; i >= 0; i--) begin
      spi_mosi = v[i];
      repeat (HALF) @(negedge clk);
      spi_sck = 1'b1;
      rb_bits = {rb_bits[62:0], spi_miso};
      oe_seen = oe_seen | spi_miso_oe;
      repeat (HALF) @(negedge clk);
      spi_sck = 1'b0;
    end
    repeat (HALF) @(negedge clk);
  endtask

  task automatic start_frame();
    rb_bits = '0;
    oe_seen = 1'b0;
    spi_nCS = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic frame(input int n, input logic [63:0] v);
    start_frame();
    send_bits(n, v);
    spi_nCS = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; n_ferr = 0;
    reset = 1'b1; spi_nCS = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
    rb_bits = '0; oe_seen = 1'b0;

    repeat (5) @(negedge clk);
    check_eq("rst_status", 64'(status), 64'h1);
    check_eq("rst_out", 64'(out), 64'h0);
    check_eq("rst_out_en", 64'(out_en), 64'h0);
    check_eq("rst_buffer_oe", 64'(buffer_oe), 64'h0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("buffer_oe_on", 64'(buffer_oe), 64'h1);
    check_eq("idle_status", 64'(status), 64'h0);
    repeat (6) @(negedge clk);

    // data write ch2, with commit latency and frame-active LED
    start_frame();
    send_bits(16, 64'h02A5);
    check_eq("status_active", 64'(status), 64'h2);
    spi_nCS = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("lat_pre", 64'(out), 64'h0);
    @(negedge clk);
    check_eq("lat_post", 64'(out), 64'h00A5_0000);
    repeat (8) @(negedge clk);
    check_eq("ferr_none", 64'(n_ferr), 64'd0);
`ifndef SPI_READBACK_EN
    check_eq("miso_off", {55'd0, oe_seen, rb_bits[7:0]}, 64'h0);
`endif

    frame(16, 64'h8101);
    check_eq("en1_set", 64'(out_en), 64'h2);
    check_eq("en1_out", 64'(out), 64'h00A5_0000);
    frame(16, 64'h8100);
    check_eq("en1_clr", 64'(out_en), 64'h0);
    frame(16, 64'h83FE);
    check_eq("en3_bit0", 64'(out_en), 64'h0);
    frame(16, 64'h83FF);
    check_eq("en3_set", 64'(out_en), 64'h8);
    frame(16, 64'h035A);
    check_eq("data_ch3", 64'(out), 64'h5AA5_0000);
    check_eq("data_ch3_en", 64'(out_en), 64'h8);

    frame(15, 64'h00FF);
    check_eq("short_ferr", 64'(n_ferr), 64'd1);
    check_eq("short_sticky", 64'(status), 64'h4);
    frame(17, 64'h003FF);
    check_eq("long_ferr", 64'(n_ferr), 64'd2);
    check_eq("long_out", 64'(out), 64'h5AA5_0000);
    frame(16, 64'h05FF);
    check_eq("range_ferr", 64'(n_ferr), 64'd3);
    frame(16, 64'h84FF);
    check_eq("range_en_ferr", 64'(n_ferr), 64'd4);
    check_eq("range_out", 64'(out), 64'h5AA5_0000);
    check_eq("range_out_en", 64'(out_en), 64'h8);

    // reset mid-frame, released while nCS still low
    start_frame();
    send_bits(5, 64'h00);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("midrst_status", 64'(status), 64'h1);
    reset = 1'b0;
    send_bits(11, 64'h177);
    spi_nCS = 1'b1;
    repeat (12) @(negedge clk);
    check_eq("midrst_out", 64'(out), 64'h0);
    check_eq("midrst_out_en", 64'(out_en), 64'h0);
    check_eq("midrst_status2", 64'(status), 64'h0);
    check_eq("midrst_ferr", 64'(n_ferr), 64'd4);

    frame(16, 64'h003C);
    check_eq("post_rst_ch0", 64'(out), 64'h0000_003C);

`ifdef SPI_READBACK_EN
    frame(16, 64'h0011);
    check_eq("rb_ch0", 64'(rb_bits[7:0]), 64'h3C);
    check_eq("rb_oe", 64'(oe_seen), 64'h1);
    check_eq("rb_new_ch0", 64'(out), 64'h0000_0011);
    frame(16, 64'h8001);
    check_eq("rb_enwrite_zero", 64'(rb_bits[7:0]), 64'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
